// File: rtl/syscall_unit.sv
// Syscall responder: latches $v0/$a0 on a decoder syscall, stalls IF/ID and
// performs print_int, print_string (memory byte walk), print_char or exit.
module syscall_unit #(
  parameter int unsigned MAX_STR_LEN = 1024,
  parameter int unsigned SVC_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             syscall,
  input  logic [SVC_W-1:0] v0,
  input  logic [31:0]      a0,
  output logic             stall,
  output logic             mem_rd,
  output logic [31:0]      mem_addr,
  input  logic [31:0]      mem_rdata,
  output logic             char_valid,
  output logic [7:0]       char_data,
  input  logic             char_ready,
  output logic             int_valid,
  output logic [31:0]      int_data,
  input  logic             int_ready,
  output logic             halted,
  output logic             bad_svc
);

  localparam int unsigned CNT_W = $clog2(MAX_STR_LEN + 1);

  localparam logic [SVC_W-1:0] SVC_PRINT_INT  = SVC_W'(1);
  localparam logic [SVC_W-1:0] SVC_PRINT_STR  = SVC_W'(4);
  localparam logic [SVC_W-1:0] SVC_EXIT       = SVC_W'(10);
  localparam logic [SVC_W-1:0] SVC_PRINT_CHAR = SVC_W'(11);
  localparam logic [CNT_W-1:0] CNT_MAX        = CNT_W'(MAX_STR_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EMIT_C,
    S_EMIT_I,
    S_DONE,
    S_HALT
  } state_t;

  state_t           state;
  logic [SVC_W-1:0] svc;
  logic [31:0]      ptr;
  logic [CNT_W-1:0] count;

  logic [7:0]       rd_byte;
  logic [31:0]      ptr_inc;
  logic [CNT_W-1:0] count_inc;

  // Big-endian byte select of the returned word, plus walk increments
  always_comb begin
    rd_byte   = 8'h00;
    ptr_inc   = ptr + 32'd1;
    count_inc = count + CNT_W'(1);
    case (ptr[1:0])
      2'd0:    rd_byte = mem_rdata[31:24];
      2'd1:    rd_byte = mem_rdata[23:16];
      2'd2:    rd_byte = mem_rdata[15:8];
      default: rd_byte = mem_rdata[7:0];
    endcase
  end

  // Pipeline stall: follows syscall in IDLE, released only in DONE otherwise
  always_comb begin
    stall = 1'b1;
    case (state)
      S_IDLE:  stall = syscall;
      S_DONE:  stall = 1'b0;
      default: stall = 1'b1;
    endcase
  end

  // Service FSM with registered handshake and memory outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      svc        <= '0;
      ptr        <= '0;
      count      <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      char_valid <= 1'b0;
      char_data  <= '0;
      int_valid  <= 1'b0;
      int_data   <= '0;
      halted     <= 1'b0;
      bad_svc    <= 1'b0;
    end else begin
      mem_rd  <= 1'b0;
      bad_svc <= 1'b0;
      case (state)
        S_IDLE: begin
          if (syscall) begin
            svc   <= v0;
            ptr   <= a0;
            count <= '0;
            if (v0 == SVC_PRINT_INT) begin
              int_valid <= 1'b1;
              int_data  <= a0;
              state     <= S_EMIT_I;
            end else if (v0 == SVC_PRINT_STR) begin
              mem_rd   <= 1'b1;
              mem_addr <= {a0[31:2], 2'b00};
              state    <= S_FETCH;
            end else if (v0 == SVC_PRINT_CHAR) begin
              char_valid <= 1'b1;
              char_data  <= a0[7:0];
              state      <= S_EMIT_C;
            end else if (v0 == SVC_EXIT) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              bad_svc <= 1'b1;
              state   <= S_DONE;
            end
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          if (rd_byte == 8'h00) begin
            state <= S_DONE;
          end else begin
            char_valid <= 1'b1;
            char_data  <= rd_byte;
            state      <= S_EMIT_C;
          end
        end
        S_EMIT_C: begin
          if (char_ready) begin
            char_valid <= 1'b0;
            if (svc == SVC_PRINT_STR) begin
              ptr   <= ptr_inc;
              count <= count_inc;
              if (count_inc == CNT_MAX) begin
                state <= S_DONE;
              end else begin
                mem_rd   <= 1'b1;
                mem_addr <= {ptr_inc[31:2], 2'b00};
                state    <= S_FETCH;
              end
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_EMIT_I: begin
          if (int_ready) begin
            int_valid <= 1'b0;
            state     <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit: vector table of complete services plus
// hand sequences for exit/halt and reset in the middle of a string.
module tb_syscall_unit;

  logic        clk;
  logic        rst_n;
  logic        syscall;
  logic [31:0] v0;
  logic [31:0] a0;
  logic        stall;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        int_valid;
  logic [31:0] int_data;
  logic        int_ready;
  logic        halted;
  logic        bad_svc;

  int checks = 0;
  int errors = 0;

  syscall_unit #(.MAX_STR_LEN(4), .SVC_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .syscall    (syscall),
    .v0         (v0),
    .a0         (a0),
    .stall      (stall),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .int_valid  (int_valid),
    .int_data   (int_data),
    .int_ready  (int_ready),
    .halted     (halted),
    .bad_svc    (bad_svc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory image used by the string walks
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h1001_0000: mem_word = 32'h0048_6900;
      32'h2000_0000: mem_word = 32'h4142_4344;
      32'h2000_0004: mem_word = 32'h4546_4748;
      default:       mem_word = 32'h0000_0000;
    endcase
  endfunction

  // One-cycle read latency; garbage whenever no read was issued
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem_word(mem_addr);
    else        mem_rdata <= 32'hDEAD_BEEF;
  end

  typedef struct {
    logic [31:0] v0;
    logic [31:0] a0;
    int          ready_lo;
    int          n_chars;
    logic [31:0] chars;
    logic        has_int;
    logic [31:0] int_val;
    int          bad;
    int          stall_cyc;
    int          n_reads;
    logic [31:0] last_addr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Run one complete service, observing every cycle, then compare
  task automatic run_vec(input string tag, input vec_t v);
    int          stall_cyc = 0;
    int          bad_cnt = 0;
    int          n_got = 0;
    logic [31:0] got_chars = 0;
    int          n_int = 0;
    logic [31:0] got_int = 0;
    int          unstable = 0;
    int          int_bad = 0;
    int          reads = 0;
    int          misaligned = 0;
    logic [31:0] last_addr = 0;
    int          cwait = 0;
    int          iwait = 0;
    logic [7:0]  first_c = 0;
    logic        timed_out = 1'b1;

    @(negedge clk);
    v0 = v.v0;
    a0 = v.a0;
    syscall = 1'b1;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (bad_svc) bad_cnt++;
      if (!stall) begin
        timed_out = 1'b0;
        break;
      end
      stall_cyc++;
      if (mem_rd) begin
        reads++;
        last_addr = mem_addr;
        if (mem_addr[1:0] != 2'b00) misaligned++;
      end
      if (char_valid) begin
        if (cwait == 0) first_c = char_data;
        else if (char_data != first_c) unstable++;
        char_ready = (cwait >= v.ready_lo);
        if (char_ready) begin
          got_chars = {got_chars[23:0], first_c};
          n_got++;
          cwait = 0;
        end else begin
          cwait++;
        end
      end else begin
        char_ready = 1'b1;
      end
      if (int_valid) begin
        if (int_data != v.int_val) int_bad++;
        int_ready = (iwait >= v.ready_lo);
        if (int_ready) begin
          n_int++;
          got_int = int_data;
          iwait = 0;
        end else begin
          iwait++;
        end
      end else begin
        int_ready = 1'b1;
      end
      @(negedge clk);
    end
    // syscall still high during DONE: it must not be re-serviced
    @(negedge clk);
    syscall = 1'b0;
    #1;
    chk({tag, "_done"},      32'(timed_out), 32'd0);
    chk({tag, "_stall_cyc"}, 32'(stall_cyc), 32'(v.stall_cyc));
    chk({tag, "_n_chars"},   32'(n_got), 32'(v.n_chars));
    chk({tag, "_chars"},     got_chars, v.chars);
    chk({tag, "_char_stab"}, 32'(unstable), 32'd0);
    chk({tag, "_n_int"},     32'(n_int), v.has_int ? 32'd1 : 32'd0);
    chk({tag, "_int_val"},   got_int, v.has_int ? v.int_val : 32'd0);
    chk({tag, "_int_stab"},  32'(int_bad), 32'd0);
    chk({tag, "_bad_svc"},   32'(bad_cnt), 32'(v.bad));
    chk({tag, "_reads"},     32'(reads), 32'(v.n_reads));
    chk({tag, "_last_addr"}, last_addr, v.last_addr);
    chk({tag, "_align"},     32'(misaligned), 32'd0);
    chk({tag, "_post_idle"}, {29'd0, stall, char_valid, int_valid}, 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          v0            a0         rl nch chars         int   int_val       bad stl rd last
    vecs[0]  = '{32'd11,  32'h0000_0041, 0, 1, 32'h0000_0041, 1'b0, 32'h0,        0, 2,  0, 32'h0};
    vecs[1]  = '{32'd11,  32'h1234_567A, 3, 1, 32'h0000_007A, 1'b0, 32'h0,        0, 5,  0, 32'h0};
    vecs[2]  = '{32'd1,   32'h1234_5678, 0, 0, 32'h0,         1'b1, 32'h1234_5678, 0, 2, 0, 32'h0};
    vecs[3]  = '{32'd1,   32'hFFFF_FFFE, 5, 0, 32'h0,         1'b1, 32'hFFFF_FFFE, 0, 7, 0, 32'h0};
    vecs[4]  = '{32'd7,   32'h0000_0041, 0, 0, 32'h0,         1'b0, 32'h0,        1, 1,  0, 32'h0};
    vecs[5]  = '{32'd0,   32'h0000_0000, 0, 0, 32'h0,         1'b0, 32'h0,        1, 1,  0, 32'h0};
    vecs[6]  = '{32'h104, 32'h0000_0041, 0, 0, 32'h0,         1'b0, 32'h0,        1, 1,  0, 32'h0};
    vecs[7]  = '{32'd5,   32'h0000_0041, 0, 0, 32'h0,         1'b0, 32'h0,        1, 1,  0, 32'h0};
    vecs[8]  = '{32'd4,   32'h1001_0001, 0, 2, 32'h0000_4869, 1'b0, 32'h0,        0, 9,  3, 32'h1001_0000};
    vecs[9]  = '{32'd4,   32'h2000_0000, 0, 4, 32'h4142_4344, 1'b0, 32'h0,        0, 13, 4, 32'h2000_0000};
    vecs[10] = '{32'd4,   32'h1001_0003, 0, 0, 32'h0,         1'b0, 32'h0,        0, 3,  1, 32'h1001_0000};
    vecs[11] = '{32'd4,   32'h2000_0006, 2, 2, 32'h0000_4748, 1'b0, 32'h0,        0, 13, 3, 32'h2000_0008};

    rst_n = 1'b0;
    syscall = 1'b0;
    v0 = 32'd0;
    a0 = 32'd0;
    char_ready = 1'b1;
    int_ready = 1'b1;
    #2;
    chk("rst_stall",      32'(stall), 32'd0);
    chk("rst_mem_rd",     32'(mem_rd), 32'd0);
    chk("rst_mem_addr",   mem_addr, 32'd0);
    chk("rst_char_valid", 32'(char_valid), 32'd0);
    chk("rst_char_data",  32'(char_data), 32'd0);
    chk("rst_int_valid",  32'(int_valid), 32'd0);
    chk("rst_int_data",   int_data, 32'd0);
    chk("rst_halted",     32'(halted), 32'd0);
    chk("rst_bad_svc",    32'(bad_svc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Reset while a string character is stuck waiting for ready
    @(negedge clk);
    v0 = 32'd4;
    a0 = 32'h1001_0001;
    syscall = 1'b1;
    char_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_char_valid", 32'(char_valid), 32'd1);
    chk("mid_char_data",  32'(char_data), 32'h48);
    rst_n = 1'b0;
    syscall = 1'b0;
    #1;
    chk("mid_rst_char_valid", 32'(char_valid), 32'd0);
    chk("mid_rst_stall",      32'(stall), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("mid_rst_hold", {29'd0, char_valid, int_valid, mem_rd}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    char_ready = 1'b1;
    run_vec("after_rst_bad", '{32'd7, 32'h0, 0, 0, 32'h0, 1'b0, 32'h0, 1, 1, 0, 32'h0});

    // Exit is sticky until reset, even with syscall dropped
    @(negedge clk);
    v0 = 32'd10;
    a0 = 32'h0;
    syscall = 1'b1;
    @(negedge clk);
    #1;
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_stall",  32'(stall), 32'd1);
    syscall = 1'b0;
    v0 = 32'd11;
    repeat (8) @(negedge clk);
    #1;
    chk("halt_sticky", {29'd0, halted, stall, char_valid}, 32'b110);
    rst_n = 1'b0;
    #1;
    chk("halt_rst", {30'd0, halted, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("halt_released", {30'd0, halted, stall}, 32'd0);
    run_vec("after_halt", vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
